serial_add_sub: RTL

Parametrised bit-serial adder/subtractor. It takes two WIDTH-bit operands and a mode bit on a start strobe, then resolves the result LSB-first, one full-adder step per clock. It reports the sum, carry-out and signed overflow, with a single-cycle done pulse. It reuses one 1-bit full-adder stage, so the arithmetic core stays small at any width.

---
 rtl/serial_add_sub.sv | 93 +++++++++
 1 files changed

// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor: one shared full-adder step per clock, LSB first.
// Reports sum, carry-out (inverted borrow when subtracting) and signed overflow.
module serial_add_sub #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out,
   output logic             overflow,
   output logic [1:0]       dbg_state,
   output logic             dbg_sub
);

   // Handshake: start is taken on any rising edge where busy is low (IDLE or DONE);
   // while busy is high start is ignored. done marks sum/carry_out/overflow valid.
   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] a_r, b_r;
   logic             c_r, sub_r;
   logic [CW-1:0]    cnt;
   logic             accept, last, s_bit, c_nxt;

   assign accept = start && (state != RUN);
   assign last   = (cnt == CW'(WIDTH-1));
   assign s_bit  = a_r[0] ^ b_r[0] ^ c_r;
   assign c_nxt  = (a_r[0] & b_r[0]) | (a_r[0] & c_r) | (b_r[0] & c_r);

   assign busy      = (state == RUN);
   assign done      = (state == DONE);
   assign dbg_state = state;
   assign dbg_sub   = sub_r;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (last)  state_nxt = DONE;
         DONE:    state_nxt = start ? RUN : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Subtraction is a + ~b + 1: invert b on load and seed the carry with 1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_r       <= '0;
         b_r       <= '0;
         c_r       <= 1'b0;
         sub_r     <= 1'b0;
         cnt       <= '0;
         sum       <= '0;
         carry_out <= 1'b0;
         overflow  <= 1'b0;
      end else if (accept) begin
         a_r   <= a;
         b_r   <= sub ? ~b : b;
         c_r   <= sub;
         sub_r <= sub;
         cnt   <= '0;
      end else if (state == RUN) begin
         a_r <= a_r >> 1;
         b_r <= b_r >> 1;
         c_r <= c_nxt;
         sum <= {s_bit, sum[WIDTH-1:1]};
         cnt <= cnt + CW'(1);
         // On the MSB step c_r is the carry in, c_nxt the carry out.
         if (last) begin
            carry_out <= c_nxt;
            overflow  <= c_r ^ c_nxt;
         end
      end
   end

endmodule
